mem_port_master: RTL and testbench

//  Per-core master port in front of the shared data-memory arbiter; one instance per core (C total).

---
 rtl/mem_port_pkg.sv | 26 ++
 rtl/mem_port_master_if.sv | 42 ++++
 rtl/mem_port_master.sv | 153 +++++++++++++++
 tb/tb_mem_port_master.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and default widths for the per-core memory port master.
// The BACKOFF state is only reachable when MEM_PORT_BACKOFF_EN is defined.
package mem_port_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    localparam int LW_DEF = 10;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_STORE  = 2'd1,
        OP_LOCK   = 2'd2,
        OP_UNLOCK = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        XFER    = 3'd2,
        LOCK    = 3'd3,
        UNLOCK  = 3'd4,
        RESP    = 3'd5,
        BACKOFF = 3'd6
    } state_t;

endpackage

// File: rtl/mem_port_master_if.sv
// Core-side, arbiter-side and mutex-side signals of one memory port master.
// The master modport is the port block itself; slave is the core/arbiter/memory side.
interface mem_port_master_if
    import mem_port_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
);
    logic          core_valid;
    logic          core_ready;
    op_t           core_op;
    logic [AW-1:0] core_adr;
    logic [DW-1:0] core_wdat;
    logic          resp_valid;
    logic [DW-1:0] resp_rdat;
    logic          mem_read_req;
    logic          mem_write_req;
    logic          mem_ac;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdat;
    logic [DW-1:0] mem_rdat;
    logic [LW-1:0] lock_adr;
    logic          lock_en;
    logic          unlock_en;
    logic          lock_ac;

    modport master (
        input  core_valid, core_op, core_adr, core_wdat, mem_ac, mem_rdat, lock_ac,
        output core_ready, resp_valid, resp_rdat, mem_read_req, mem_write_req,
               mem_read, mem_write, mem_adr, mem_wdat, lock_adr, lock_en, unlock_en
    );

    modport slave (
        output core_valid, core_op, core_adr, core_wdat, mem_ac, mem_rdat, lock_ac,
        input  core_ready, resp_valid, resp_rdat, mem_read_req, mem_write_req,
               mem_read, mem_write, mem_adr, mem_wdat, lock_adr, lock_en, unlock_en
    );

endinterface

// File: rtl/mem_port_master.sv
// Per-core master port: sequences one LOAD/STORE/LOCK/UNLOCK op through the arbiter.
// Build option: MEM_PORT_BACKOFF_EN adds an idle BACKOFF period after a denied lock.
//
//  state   | meaning
//  IDLE    | ready to accept an op from the core
//  REQ     | read/write request raised, waiting for grant
//  XFER    | granted, single-cycle access strobe
//  LOCK    | lock attempt on the mutex
//  UNLOCK  | unlock request, waiting for acknowledge
//  RESP    | one-cycle completion pulse to the core
//  BACKOFF | idle countdown after a denied lock
module mem_port_master
    import mem_port_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int LW      = LW_DEF,
    parameter int BACKOFF = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_port_master_if.master bus
);

    if (BACKOFF < 1) begin : g_backoff_chk
        $error("mem_port_master: BACKOFF must be >= 1");
    end

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic [LW-1:0] lock_adr_q, lock_adr_d;
    logic [DW-1:0] rdat_q, rdat_d;

`ifdef MEM_PORT_BACKOFF_EN
    localparam int BCW = $clog2(BACKOFF + 1);
    logic [BCW-1:0] bcnt_q, bcnt_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_LOAD;
            adr_q      <= '0;
            wdat_q     <= '0;
            lock_adr_q <= '0;
            rdat_q     <= '0;
`ifdef MEM_PORT_BACKOFF_EN
            bcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            lock_adr_q <= lock_adr_d;
            rdat_q     <= rdat_d;
`ifdef MEM_PORT_BACKOFF_EN
            bcnt_q     <= bcnt_d;
`endif
        end
    end

    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        adr_d             = adr_q;
        wdat_d            = wdat_q;
        lock_adr_d        = lock_adr_q;
        rdat_d            = rdat_q;
`ifdef MEM_PORT_BACKOFF_EN
        bcnt_d            = bcnt_q;
`endif
        bus.core_ready    = 1'b0;
        bus.resp_valid    = 1'b0;
        bus.mem_read_req  = 1'b0;
        bus.mem_write_req = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.lock_en       = 1'b0;
        bus.unlock_en     = 1'b0;

        case (state_q)
            IDLE: begin
                bus.core_ready = 1'b1;
                if (bus.core_valid) begin
                    op_d       = bus.core_op;
                    adr_d      = bus.core_adr;
                    wdat_d     = bus.core_wdat;
                    lock_adr_d = bus.core_adr[LW-1:0];
                    rdat_d     = '0;
                    case (bus.core_op)
                        OP_LOCK:   state_d = LOCK;
                        OP_UNLOCK: state_d = UNLOCK;
                        default:   state_d = REQ;
                    endcase
                end
            end
            REQ: begin
                bus.mem_read_req  = (op_q == OP_LOAD);
                bus.mem_write_req = (op_q == OP_STORE);
                if (bus.mem_ac) state_d = XFER;
            end
            XFER: begin
                bus.mem_read_req  = (op_q == OP_LOAD);
                bus.mem_write_req = (op_q == OP_STORE);
                bus.mem_read      = (op_q == OP_LOAD);
                bus.mem_write     = (op_q == OP_STORE);
                // A grant lost mid-access means the strobe did not land; go retry it.
                if (bus.mem_ac) begin
                    if (op_q == OP_LOAD) rdat_d = bus.mem_rdat;
                    state_d = RESP;
                end else begin
                    state_d = REQ;
                end
            end
            LOCK: begin
                bus.lock_en = 1'b1;
                if (bus.lock_ac) begin
                    state_d = RESP;
                end else begin
`ifdef MEM_PORT_BACKOFF_EN
                    state_d = BACKOFF;
                    bcnt_d  = BCW'(BACKOFF - 1);
`endif
                end
            end
`ifdef MEM_PORT_BACKOFF_EN
            BACKOFF: begin
                if (bcnt_q == '0) state_d = LOCK;
                else              bcnt_d  = bcnt_q - 1'b1;
            end
`endif
            UNLOCK: begin
                bus.unlock_en = 1'b1;
                if (bus.lock_ac) state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                rdat_d         = '0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_adr   = adr_q;
    assign bus.mem_wdat  = wdat_q;
    assign bus.lock_adr  = lock_adr_q;
    assign bus.resp_rdat = rdat_q;

endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master; expected responses go through a scoreboard queue.
// Compile with the same MEM_PORT_BACKOFF_EN setting as the design.
module tb_mem_port_master;
    import mem_port_pkg::*;

    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int LW        = 10;
    localparam int BACKOFF   = 4;
    localparam int LOCK_DENY = 3;
`ifdef MEM_PORT_BACKOFF_EN
    localparam bit BO_EN = 1'b1;
`else
    localparam bit BO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_master_if #(.AW(AW), .DW(DW), .LW(LW)) mif ();

    mem_port_master #(.AW(AW), .DW(DW), .LW(LW), .BACKOFF(BACKOFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.master)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb[$];
    logic          use_fixed;
    logic [DW-1:0] rdat_fixed;
    int            lock_attempts;

    // Memory model: fixed word when requested, otherwise an address-derived pattern.
    assign mif.mem_rdat = use_fixed ? rdat_fixed : (mif.mem_adr ^ 16'h5A5A);
    // Mutex model: deny the first LOCK_DENY lock attempts, always acknowledge unlocks.
    assign mif.lock_ac  = (mif.lock_en && (lock_attempts >= LOCK_DENY)) || mif.unlock_en;

    always @(posedge clk) begin
        if (reset)            lock_attempts <= 0;
        else if (mif.lock_en) lock_attempts <= lock_attempts + 1;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response scoreboard and protocol invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            chk1("req_exclusive",
                 (int'(mif.mem_read_req) + int'(mif.mem_write_req) +
                  int'(mif.lock_en) + int'(mif.unlock_en)) <= 1, 1'b1);
            chk1("strobe_in_xfer",
                 (!mif.mem_read || mif.mem_read_req) && (!mif.mem_write || mif.mem_write_req), 1'b1);
            if (mif.resp_valid) begin
                chk1("resp_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) chk16("resp_rdat", mif.resp_rdat, sb.pop_front());
            end else begin
                chk16("rdat_idle_zero", mif.resp_rdat, 16'h0000);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        mif.core_valid = 1'b0;
        mif.core_op    = OP_LOAD;
        mif.core_adr   = '0;
        mif.core_wdat  = '0;
        mif.mem_ac     = 1'b0;
        use_fixed      = 1'b0;
        rdat_fixed     = '0;
        repeat (3) @(negedge clk);
        chk1("rst_core_ready", mif.core_ready, 1'b1);
        chk1("rst_read_req", mif.mem_read_req, 1'b0);
        chk1("rst_resp_valid", mif.resp_valid, 1'b0);
        chk16("rst_mem_adr", mif.mem_adr, 16'h0000);
        reset = 1'b0;

        // LOAD with immediate grant
        @(negedge clk);
        chk1("t1_ready0", mif.core_ready, 1'b1);
        mif.core_valid = 1'b1;
        mif.core_op    = OP_LOAD;
        mif.core_adr   = 16'h0010;
        mif.mem_ac     = 1'b1;
        use_fixed      = 1'b1;
        rdat_fixed     = 16'hBEEF;
        sb.push_back(16'hBEEF);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk1("t1_read_req", mif.mem_read_req, (c == 1) || (c == 2));
            chk1("t1_mem_read", mif.mem_read, c == 2);
            chk1("t1_resp_valid", mif.resp_valid, c == 3);
            chk1("t1_core_ready", mif.core_ready, c >= 4);
            if (c <= 3) chk16("t1_mem_adr", mif.mem_adr, 16'h0010);
            if (c == 1) mif.core_valid = 1'b0;
        end

        // STORE with grant withheld for five cycles
        @(negedge clk);
        mif.core_valid = 1'b1;
        mif.core_op    = OP_STORE;
        mif.core_adr   = 16'h0020;
        mif.core_wdat  = 16'h1234;
        mif.mem_ac     = 1'b0;
        sb.push_back(16'h0000);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk1("t2_write_req", mif.mem_write_req, c <= 7);
            chk1("t2_mem_write", mif.mem_write, c == 7);
            chk1("t2_read_req", mif.mem_read_req, 1'b0);
            chk1("t2_resp_valid", mif.resp_valid, c == 8);
            if (c <= 8) begin
                chk16("t2_mem_adr", mif.mem_adr, 16'h0020);
                chk16("t2_mem_wdat", mif.mem_wdat, 16'h1234);
            end
            if (c == 1) begin
                mif.core_valid = 1'b0;
                mif.core_adr   = 16'hFFFF;
                mif.core_wdat  = 16'hFFFF;
            end
            if (c == 6) mif.mem_ac = 1'b1;
        end

        // LOCK denied three times
        @(negedge clk);
        mif.core_valid = 1'b1;
        mif.core_op    = OP_LOCK;
        mif.core_adr   = 16'd5;
        sb.push_back(16'h0000);
        for (int c = 1; c <= (BO_EN ? 18 : 6); c++) begin
            @(negedge clk);
            chk1("t3_lock_en", mif.lock_en,
                 BO_EN ? ((c <= 16) && ((c - 1) % 5 == 0)) : (c <= 4));
            chk1("t3_resp_valid", mif.resp_valid, c == (BO_EN ? 17 : 5));
            chk1("t3_core_ready", mif.core_ready, c > (BO_EN ? 17 : 5));
            chk1("t3_unlock_en", mif.unlock_en, 1'b0);
            if (c <= (BO_EN ? 17 : 5)) chk16("t3_lock_adr", {6'b0, mif.lock_adr}, 16'd5);
            if (c == 1) mif.core_valid = 1'b0;
        end

        // UNLOCK acknowledged at once
        @(negedge clk);
        mif.core_valid = 1'b1;
        mif.core_op    = OP_UNLOCK;
        mif.core_adr   = 16'd5;
        sb.push_back(16'h0000);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk1("t4_unlock_en", mif.unlock_en, c == 1);
            chk1("t4_lock_en", mif.lock_en, 1'b0);
            chk1("t4_resp_valid", mif.resp_valid, c == 2);
            chk1("t4_core_ready", mif.core_ready, c == 3);
            if (c <= 2) chk16("t4_lock_adr", {6'b0, mif.lock_adr}, 16'd5);
            if (c == 1) mif.core_valid = 1'b0;
        end

        // Reset while a LOAD waits for grant
        @(negedge clk);
        mif.core_valid = 1'b1;
        mif.core_op    = OP_LOAD;
        mif.core_adr   = 16'h0040;
        mif.mem_ac     = 1'b0;
        use_fixed      = 1'b0;
        sb.push_back(16'h0040 ^ 16'h5A5A);
        @(negedge clk);
        chk1("t5_read_req_pre", mif.mem_read_req, 1'b1);
        mif.core_valid = 1'b0;
        reset          = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        chk1("t5_read_req", mif.mem_read_req, 1'b0);
        chk1("t5_mem_read", mif.mem_read, 1'b0);
        chk1("t5_core_ready", mif.core_ready, 1'b1);
        chk1("t5_resp_valid", mif.resp_valid, 1'b0);
        chk16("t5_mem_adr", mif.mem_adr, 16'h0000);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1("t5_idle_ready", mif.core_ready, 1'b1);
            chk1("t5_idle_read_req", mif.mem_read_req, 1'b0);
        end

        // Back-to-back LOADs with core_valid held high
        mif.mem_ac     = 1'b1;
        mif.core_op    = OP_LOAD;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            chk1("t6_core_ready", mif.core_ready, (c % 4) == 0);
            chk1("t6_mem_read", mif.mem_read, (c % 4) == 2);
            if (c == 12) begin
                mif.core_valid = 1'b0;
            end else begin
                mif.core_valid = 1'b1;
                mif.core_adr   = 16'h0100 + 16'(c);
                if ((c % 4) == 0) sb.push_back((16'h0100 + 16'(c)) ^ 16'h5A5A);
            end
        end
        repeat (4) @(negedge clk);
        chk1("sb_drained", sb.size() == 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
